// File: rtl/seg_scan_display.sv
// Time-multiplexed 4-digit common-anode display driver for the calculator ALU result.
// Holds a per-frame snapshot of the inputs and shows a blinking "Err" on divide-by-zero.
module seg_scan_display #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       sign_result,
  input  logic       div_by_zero_flag,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_strobe
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  logic [TW-1:0] tick_reg;
  logic [1:0]    digit_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          blink_on_reg;
  logic          load_pending_reg;
  logic [3:0]    snap_hundreds_reg;
  logic [3:0]    snap_tens_reg;
  logic [3:0]    snap_ones_reg;
  logic          snap_sign_reg;
  logic          snap_ok_reg;
  logic [6:0]    seg_reg;
  logic [3:0]    an_reg;
  logic          frame_strobe_reg;

  logic          tick_wrap;
  logic          capture;
  logic          an_off;
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic [6:0]    digit_glyph [4];

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Glyph for one digit position, including leading-zero blanking and the "Err" overlay.
  function automatic logic [6:0] glyph_for(input logic [1:0] pos, input logic [3:0] h,
                                           input logic [3:0] t, input logic [3:0] o,
                                           input logic sgn, input logic ok);
    logic [6:0] g;
    g = SEG_BLANK;
    if (!ok) begin
      case (pos)
        2'd0, 2'd1: g = SEG_R;
        2'd2:       g = SEG_E;
        default:    g = SEG_BLANK;
      endcase
    end else begin
      case (pos)
        2'd0:    g = bcd_to_seg(o);
        2'd1:    g = (h == 4'd0 && t == 4'd0) ? SEG_BLANK : bcd_to_seg(t);
        2'd2:    g = (h == 4'd0) ? SEG_BLANK : bcd_to_seg(h);
        default: g = (!sgn && {h, t, o} != 12'd0) ? SEG_MINUS : SEG_BLANK;
      endcase
    end
    return g;
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_glyph
    assign digit_glyph[gi] = glyph_for(2'(gi), snap_hundreds_reg, snap_tens_reg,
                                       snap_ones_reg, snap_sign_reg, snap_ok_reg);
  end

  assign tick_wrap = (tick_reg == TW'(REFRESH_DIV - 1));
  assign capture   = load_pending_reg || (tick_wrap && digit_reg == 2'd3);

  // Anodes stay dark during the anti-ghosting window and during the off half of the error blink.
  assign an_off   = (tick_reg < TW'(BLANK_CYC)) || (!snap_ok_reg && !blink_on_reg);
  assign an_next  = an_off ? 4'b1111 : ~(4'b0001 << digit_reg);
  assign seg_next = an_off ? SEG_BLANK : digit_glyph[digit_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_reg          <= '0;
      digit_reg         <= 2'd0;
      frame_cnt_reg     <= '0;
      blink_on_reg      <= 1'b1;
      load_pending_reg  <= 1'b1;
      snap_hundreds_reg <= 4'd0;
      snap_tens_reg     <= 4'd0;
      snap_ones_reg     <= 4'd0;
      snap_sign_reg     <= 1'b1;
      snap_ok_reg       <= 1'b1;
      seg_reg           <= SEG_BLANK;
      an_reg            <= 4'b1111;
      frame_strobe_reg  <= 1'b0;
    end else begin
      tick_reg <= tick_wrap ? '0 : tick_reg + TW'(1);
      if (tick_wrap) begin
        digit_reg <= digit_reg + 2'd1;
      end
      frame_strobe_reg <= capture;
      if (capture) begin
        load_pending_reg  <= 1'b0;
        snap_hundreds_reg <= hundreds;
        snap_tens_reg     <= tens;
        snap_ones_reg     <= ones;
        snap_sign_reg     <= sign_result;
        snap_ok_reg       <= div_by_zero_flag;
        if (frame_cnt_reg == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt_reg <= '0;
          blink_on_reg  <= ~blink_on_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FW'(1);
        end
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  assign seg          = seg_reg;
  assign an           = an_reg;
  assign frame_strobe = frame_strobe_reg;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: cycle-count reference model checked every cycle, plus literal spot checks.
module tb_seg_scan_display;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;

  localparam logic [6:0] FONT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                       7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                       7'b0000000, 7'b0010000};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] hundreds = 4'd0, tens = 4'd0, ones = 4'd0;
  logic       sign_result = 1'b1, div_by_zero_flag = 1'b1;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_strobe;

  int n_checks = 0;
  int n_fail = 0;

  seg_scan_display #(.REFRESH_DIV(RD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .hundreds(hundreds), .tens(tens), .ones(ones),
    .sign_result(sign_result), .div_by_zero_flag(div_by_zero_flag),
    .seg(seg), .an(an), .frame_strobe(frame_strobe)
  );

  always #5 clk = ~clk;

  // Reference model: everything follows from k, the number of clock edges since reset release.
  bit         model_valid = 0;
  int         k, m_tick, m_dig, m_caps;
  bit         m_on;
  logic [3:0] sh, st, so;
  logic       ss, sok;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_fs;

  function automatic logic [6:0] font_of(input logic [3:0] d);
    return (d > 4'd9) ? 7'h7F : FONT[d];
  endfunction

  function automatic logic [6:0] model_glyph(input int pos);
    int value;
    value = 100 * int'(sh) + 10 * int'(st) + int'(so);
    if (!sok) return (pos == 3) ? 7'h7F : (pos == 2) ? 7'b0000110 : 7'b0101111;
    case (pos)
      0: return font_of(so);
      1: return (sh == 0 && st == 0) ? 7'h7F : font_of(st);
      2: return (sh == 0) ? 7'h7F : font_of(sh);
      default: return (!ss && value != 0) ? 7'b0111111 : 7'h7F;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_valid = 1;
      k = 0;
      sh = 0; st = 0; so = 0; ss = 1; sok = 1;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_fs = 0;
    end else if (model_valid) begin
      m_tick = k % RD;
      m_dig  = (k / RD) % 4;
      m_caps = (k == 0) ? 0 : 1 + k / FRAME;
      m_on   = ((m_caps / BF) % 2) == 0;
      if (m_tick < BC || (!sok && !m_on)) begin
        exp_an = 4'hF; exp_seg = 7'h7F;
      end else begin
        exp_an = 4'hF & ~(4'd1 << m_dig);
        exp_seg = model_glyph(m_dig);
      end
      exp_fs = (k == 0) || (k % FRAME == FRAME - 1);
      if (exp_fs) begin
        sh = hundreds; st = tens; so = ones; ss = sign_result; sok = div_by_zero_flag;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_checks++;
      if (an !== exp_an || seg !== exp_seg || frame_strobe !== exp_fs)
        $display("FAIL model k=%0d: an=%b seg=%b fs=%b, required an=%b seg=%b fs=%b",
                 k, an, seg, frame_strobe, exp_an, exp_seg, exp_fs);
      else
        $display("cycle k=%0d an=%b seg=%b fs=%b ok", k, an, seg, frame_strobe);
    end
  end

  task automatic check_lit(input string name, input logic [10:0] got, input logic [10:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic wait_strobe(input string name);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (frame_strobe === 1'b1) break;
    end
    if (i == 100) begin
      n_checks++; n_fail++;
      $display("FAIL %s: no frame_strobe within 100 cycles", name);
    end
  endtask

  task automatic wait_an(input string name, input logic [3:0] a, input logic [6:0] s);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (an === a) break;
    end
    if (i == 100) begin
      n_checks++; n_fail++;
      $display("FAIL %s: an never became %b", name, a);
    end else begin
      check_lit(name, {4'h0, seg}, {4'h0, s});
    end
  endtask

  task automatic set_in(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                        input logic sg, input logic ok);
    hundreds = h; tens = t; ones = o; sign_result = sg; div_by_zero_flag = ok;
  endtask

  // Model failures are counted here so the summary reflects every per-cycle comparison.
  always @(negedge clk) begin
    if (model_valid && (an !== exp_an || seg !== exp_seg || frame_strobe !== exp_fs)) n_fail++;
  end

  int cnt0;

  initial begin
    set_in(4'd1, 4'd2, 4'd3, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    // Reset asserted mid-scan
    reset = 1'b1;
    @(negedge clk);
    check_lit("reset_an_seg", {an, seg}, {4'hF, 7'h7F});
    check_lit("reset_strobe", {10'd0, frame_strobe}, 11'd0);
    reset = 1'b0;
    @(negedge clk);
    check_lit("first_strobe", {10'd0, frame_strobe}, 11'd1);
    wait_an("reset_digit0", 4'b1110, 7'b0110000);

    // 1/2/3 positive across a frame, with per-anode duty count
    wait_an("p123_ones", 4'b1110, 7'b0110000);
    wait_an("p123_tens", 4'b1101, 7'b0100100);
    wait_an("p123_hund", 4'b1011, 7'b1111001);
    wait_an("p123_sign", 4'b0111, 7'b1111111);
    cnt0 = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (an === 4'b1110) cnt0++;
    end
    check_lit("duty_digit0", 11'(cnt0), 11'd3);

    // 0/0/7 negative, then negative zero
    set_in(4'd0, 4'd0, 4'd7, 1'b0, 1'b1);
    wait_strobe("neg7_strobe");
    wait_an("neg7_ones", 4'b1110, 7'b1111000);
    wait_an("neg7_tens", 4'b1101, 7'b1111111);
    wait_an("neg7_hund", 4'b1011, 7'b1111111);
    wait_an("neg7_sign", 4'b0111, 7'b0111111);
    set_in(4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    wait_strobe("negz_strobe");
    wait_an("negz_ones", 4'b1110, 7'b1000000);
    wait_an("negz_sign", 4'b0111, 7'b1111111);

    // Coherency: a change inside a frame waits for the next capture
    set_in(4'd0, 4'd0, 4'd5, 1'b1, 1'b1);
    wait_strobe("coh_strobe");
    wait_an("coh_five", 4'b1110, 7'b0010010);
    ones = 4'd9;
    @(negedge clk);
    check_lit("coh_hold", {an, seg}, {4'b1110, 7'b0010010});
    wait_an("coh_hold_d1", 4'b1101, 7'b1111111);
    wait_strobe("coh_strobe2");
    wait_an("coh_nine", 4'b1110, 7'b0010000);

    // Error mode and recovery
    set_in(4'd4, 4'd5, 4'd6, 1'b1, 1'b0);
    wait_strobe("err_strobe");
    wait_an("err_E", 4'b1011, 7'b0000110);
    wait_an("err_r", 4'b1110, 7'b0101111);
    set_in(4'd4, 4'd5, 4'd6, 1'b1, 1'b1);
    wait_strobe("rec_strobe");
    wait_an("rec_ones", 4'b1110, 7'b0000010);

    // Invalid BCD in the ones digit
    set_in(4'd2, 4'd0, 4'hC, 1'b1, 1'b1);
    wait_strobe("bad_strobe");
    wait_an("bad_ones", 4'b1110, 7'b1111111);
    wait_an("bad_tens", 4'b1101, 7'b1000000);
    wait_an("bad_hund", 4'b1011, 7'b0100100);

    // Randomized inputs at random times, with occasional mid-scan resets
    for (int it = 0; it < 150; it++) begin
      repeat ($urandom_range(1, 40)) @(negedge clk);
      hundreds = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      tens     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 9));
      ones     = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) begin hundreds = 4'd0; tens = 4'd0; end
      sign_result      = 1'($urandom_range(0, 1));
      div_by_zero_flag = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (FRAME) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
